// File: rtl/screen_sequencer.sv
// Purpose: game-flow FSM choosing the full-screen image, fade level and gameplay enable.
// Latency: all outputs are registered and change only at the frame-start tick. They are visible from pixel (1,0).
// Backpressure: none. Input pulses are latched into pending flags and then consumed at the next frame tick.
module screen_sequencer #(
    parameter int WIN_FRAMES       = 300,
    parameter int DEATH_FRAMES     = 120,
    parameter int START_LIVES      = 3,
    parameter int FADE_STEP_FRAMES = 4
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       start_btn,
    input  logic       level_clear,
    input  logic       mario_dead,
    output logic [1:0] screen_sel,
    output logic [3:0] fade,
    output logic       game_run,
    output logic [1:0] lives
);

    typedef enum logic [2:0] {
        S_TITLE    = 3'd0,
        S_FADE_IN  = 3'd1,
        S_PLAY     = 3'd2,
        S_WIN      = 3'd3,
        S_DEATH    = 3'd4,
        S_FADE_OUT = 3'd5,
        S_GAMEOVER = 3'd6
    } state_t;

    localparam logic [8:0] WIN_LAST   = 9'(WIN_FRAMES - 1);
    localparam logic [8:0] DEATH_LAST = 9'(DEATH_FRAMES - 1);
    localparam logic [3:0] STEP_LAST  = 4'(FADE_STEP_FRAMES - 1);
    localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] fade_q, fade_d;
    logic       run_q, run_d;
    logic [1:0] lives_q, lives_d;
    logic [8:0] cnt_q, cnt_d;
    logic [3:0] step_q, step_d;
    logic       start_q;
    logic       start_pend_q, start_pend_d;
    logic       clr_pend_q, clr_pend_d;
    logic       dead_pend_q, dead_pend_d;

    logic frame_tick;
    logic start_rise;
    logic state_chg;

    assign frame_tick = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign start_rise = start_btn & ~start_q;

    // Next-state, counter and output decisions. Nothing moves except on the frame tick.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        fade_d  = fade_q;
        run_d   = run_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        if (frame_tick) begin
            case (state_q)
                S_TITLE: begin
                    if (start_pend_q) begin
                        state_d = S_FADE_IN;
                        lives_d = LIVES_INIT;
                        fade_d  = 4'd0;
                    end
                end
                S_FADE_IN: begin
                    if (fade_q == 4'd15) begin
                        state_d = S_PLAY;
                    end else if (step_q == STEP_LAST) begin
                        fade_d = fade_q + 4'd1;
                        step_d = 4'd0;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
                S_PLAY: begin
                    // A level clear beats a death that is latched in the same frame
                    if (clr_pend_q) begin
                        state_d = S_WIN;
                    end else if (dead_pend_q) begin
                        state_d = S_DEATH;
                    end
                end
                S_WIN: begin
                    if (cnt_q == WIN_LAST) begin
                        state_d = S_FADE_OUT;
                        fade_d  = 4'd15;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
                S_DEATH: begin
                    if (cnt_q == DEATH_LAST) begin
                        if (lives_q > 2'd1) begin
                            lives_d = lives_q - 2'd1;
                            state_d = S_FADE_IN;
                            fade_d  = 4'd0;
                        end else begin
                            lives_d = 2'd0;
                            state_d = S_GAMEOVER;
                        end
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
                S_FADE_OUT: begin
                    if (fade_q == 4'd0) begin
                        state_d = S_TITLE;
                        fade_d  = 4'd15;
                    end else if (step_q == STEP_LAST) begin
                        fade_d = fade_q - 4'd1;
                        step_d = 4'd0;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
                S_GAMEOVER: begin
                    if (start_pend_q) begin
                        state_d = S_TITLE;
                    end
                end
                default: begin
                    state_d = S_TITLE;
                    fade_d  = 4'd15;
                end
            endcase
            if (state_d != state_q) begin
                cnt_d  = 9'd0;
                step_d = 4'd0;
            end
            case (state_d)
                S_TITLE:    sel_d = 2'd0;
                S_WIN,
                S_FADE_OUT: sel_d = 2'd2;
                S_GAMEOVER: sel_d = 2'd3;
                default:    sel_d = 2'd1;
            endcase
            run_d = (state_d == S_PLAY);
        end
    end

    assign state_chg = frame_tick && (state_d != state_q);

    // Pending flags: sticky between ticks, gated by state, and flushed on every state change.
    always_comb begin
        start_pend_d = 1'b0;
        clr_pend_d   = 1'b0;
        dead_pend_d  = 1'b0;
        if (!state_chg) begin
            if (state_q == S_TITLE || state_q == S_GAMEOVER) begin
                start_pend_d = start_pend_q | start_rise;
            end
            if (state_q == S_PLAY) begin
                clr_pend_d  = clr_pend_q | level_clear;
                dead_pend_d = dead_pend_q | mario_dead;
            end
        end
    end

    // State, counters, flags and registered outputs. The reset is synchronous.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q      <= S_TITLE;
            sel_q        <= 2'd0;
            fade_q       <= 4'd15;
            run_q        <= 1'b0;
            lives_q      <= 2'd0;
            cnt_q        <= 9'd0;
            step_q       <= 4'd0;
            start_q      <= 1'b0;
            start_pend_q <= 1'b0;
            clr_pend_q   <= 1'b0;
            dead_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            fade_q       <= fade_d;
            run_q        <= run_d;
            lives_q      <= lives_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            start_q      <= start_btn;
            start_pend_q <= start_pend_d;
            clr_pend_q   <= clr_pend_d;
            dead_pend_q  <= dead_pend_d;
        end
    end

    assign screen_sel = sel_q;
    assign fade       = fade_q;
    assign game_run   = run_q;
    assign lives      = lives_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Purpose: directed bench for screen_sequencer using a short 4-cycle frame so that long holds stay cheap.
// Latency: outputs are sampled at the negedge that follows each frame tick or reset edge.
// Backpressure: not applicable. Pulses are placed either on the tick cycle or on the cycle after it.
module tb_screen_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       start_btn;
    logic       level_clear;
    logic       mario_dead;
    logic [1:0] screen_sel;
    logic [3:0] fade;
    logic       game_run;
    logic [1:0] lives;

    int checks   = 0;
    int failures = 0;

    screen_sequencer #(
        .WIN_FRAMES      (300),
        .DEATH_FRAMES    (120),
        .START_LIVES     (3),
        .FADE_STEP_FRAMES(4)
    ) dut (
        .vga_clk    (clk),
        .reset_n    (reset_n),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .start_btn  (start_btn),
        .level_clear(level_clear),
        .mario_dead (mario_dead),
        .screen_sel (screen_sel),
        .fade       (fade),
        .game_run   (game_run),
        .lives      (lives)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int sel, input int fd, input int run, input int lv);
        chk({tag, ".screen_sel"}, {30'd0, screen_sel}, sel);
        chk({tag, ".fade"},       {28'd0, fade},       fd);
        chk({tag, ".game_run"},   {31'd0, game_run},   run);
        chk({tag, ".lives"},      {30'd0, lives},      lv);
    endtask

    // One frame: a tick cycle at (0,0), then three drawn cycles. A pulse is put on the tick cycle or on the cycle after it.
    task automatic frame(input bit lc, input bit md, input bit sb, input bit on_tick);
        logic sv;
        sv = start_btn;
        @(negedge clk);
        DrawX = 10'd0; DrawY = 10'd0;
        if (on_tick) begin
            level_clear = lc; mario_dead = md;
            if (sb) start_btn = 1'b1;
        end
        @(negedge clk);
        DrawX = 10'd1; DrawY = 10'd0;
        level_clear = 1'b0; mario_dead = 1'b0; start_btn = sv;
        if (!on_tick) begin
            level_clear = lc; mario_dead = md;
            if (sb) start_btn = 1'b1;
        end
        @(negedge clk);
        DrawX = 10'd2;
        level_clear = 1'b0; mario_dead = 1'b0; start_btn = sv;
        @(negedge clk);
        DrawX = 10'd3; DrawY = 10'd1;
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) frame(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Call this just after the FADE_IN entry tick. The fade then climbs by one every 4 frames and PLAY starts 61 frames later.
    task automatic fade_in_to_play(input int lv);
        for (int k = 1; k <= 60; k++) begin
            frame(1'b0, 1'b0, 1'b0, 1'b0);
            chk("fade_in.fade", {28'd0, fade}, k / 4);
            chk("fade_in.game_run", {31'd0, game_run}, 0);
        end
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("play.entry", 1, 15, 1, lv);
    endtask

    task automatic start_game();
        frame(1'b0, 1'b0, 1'b1, 1'b0);
        chk("title.before_tick", {30'd0, screen_sel}, 0);
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("fade_in.entry", 1, 0, 0, 3);
        fade_in_to_play(3);
    endtask

    task automatic die(input int lv);
        frame(1'b0, 1'b1, 1'b0, 1'b0);
        chk("play.dead_latched", {31'd0, game_run}, 1);
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("death.entry", 1, 15, 0, lv);
        run_frames(119);
        chk_out("death.last", 1, 15, 0, lv);
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        if (lv > 1) begin
            chk_out("death.to_fade_in", 1, 0, 0, lv - 1);
            fade_in_to_play(lv - 1);
        end else begin
            chk_out("gameover.entry", 3, 15, 0, 0);
        end
    endtask

    initial begin
        reset_n = 1'b0; DrawX = 10'd5; DrawY = 10'd5;
        start_btn = 1'b0; level_clear = 1'b0; mario_dead = 1'b0;
        repeat (3) @(negedge clk);
        chk_out("reset", 0, 15, 0, 0);
        reset_n = 1'b1;

        run_frames(2);
        chk_out("title.idle", 0, 15, 0, 0);

        // A start pulse on the tick cycle is latched, and it acts only at the next tick
        frame(1'b0, 1'b0, 1'b1, 1'b1);
        chk_out("title.tick_pulse_latched", 0, 15, 0, 0);
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("fade_in.entry_tick_pulse", 1, 0, 0, 3);
        run_frames(28);
        chk("fade_in.mid_fade", {28'd0, fade}, 7);

        // A reset in the middle of a fade, on a non-tick cycle, acts on the next edge
        reset_n = 1'b0;
        @(negedge clk);
        chk_out("reset.mid_fade", 0, 15, 0, 0);
        reset_n = 1'b1;
        run_frames(2);
        chk_out("title.after_reset", 0, 15, 0, 0);

        // A normal game that ends in a win. A level_clear during WIN must not change the hold.
        start_game();
        frame(1'b1, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("win.entry", 2, 15, 0, 3);
        run_frames(49);
        frame(1'b1, 1'b0, 1'b0, 1'b0);
        run_frames(252);
        chk_out("win.hold", 2, 15, 0, 3);
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("fade_out.first_steps", 2, 15, 0, 3);
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("fade_out.first_dec", 2, 14, 0, 3);
        run_frames(56);
        chk_out("fade_out.black", 2, 0, 0, 3);
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("fade_out.to_title", 0, 15, 0, 3);

        // Three deaths lead to game over, and then a start press returns to title
        start_game();
        die(3);
        die(2);
        die(1);
        run_frames(3);
        chk_out("gameover.hold", 3, 15, 0, 0);
        frame(1'b0, 1'b0, 1'b1, 1'b0);
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("gameover.to_title", 0, 15, 0, 0);

        // level_clear and mario_dead in the same cycle give WIN, and lives stays the same
        start_game();
        frame(1'b1, 1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("both.win", 2, 15, 0, 3);
        run_frames(361);
        chk_out("both.to_title", 0, 15, 0, 3);

        // A held start key counts as one press. A later pulse during PLAY is ignored.
        start_btn = 1'b1;
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("held.fade_in_entry", 1, 0, 0, 3);
        fade_in_to_play(3);
        start_btn = 1'b0;
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b1, 1'b0);
        run_frames(3);
        chk_out("held.play_stays", 1, 15, 1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Game-flow controller that decides which full-screen image (title, level, win, game over) the VGA drawing path shows, and when. It runs on the pixel clock and watches DrawX/DrawY to find frame boundaries. Screen selection, fade brightness and the gameplay-enable bit change only at the frame boundary, so a frame never tears. The outputs drive the screen-image mux, the palette brightness scaler and the gameplay logic enable.

## Interface
- WIN_FRAMES, 300: frames the win screen is held (1..511).
- DEATH_FRAMES, 120: frames frozen after a death (1..511).
- START_LIVES, 3: lives loaded on a new game (1..3).
- FADE_STEP_FRAMES, 4: frames per fade brightness step (1..15).

- vga_clk, input, 1: pixel clock; all logic is on its rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- DrawX, input, 10: current pixel column.
- DrawY, input, 10: current pixel row.
- start_btn, input, 1: start key level; already synchronous to vga_clk.
- level_clear, input, 1: one-or-more-cycle pulse from gameplay.
- mario_dead, input, 1: one-or-more-cycle pulse from gameplay.
- screen_sel, output, 2: selected image. 0 = title, 1 = level, 2 = win, 3 = game over.
- fade, output, 4: brightness for the palette scaler. 0 = black, 15 = full.
- game_run, output, 1: gameplay logic enable.
- lives, output, 2: remaining lives.

## Operation
- frame_tick is combinational: (DrawX == 0 && DrawY == 0). It is true for exactly one vga_clk per frame.
- All state, counter and output updates happen only on edges where frame_tick = 1, except the pending flags.
- Pending flags:
  - start_pend is set on a rising edge of start_btn, detected against a registered copy.
  - clr_pend is set when level_clear = 1 in PLAY.
  - dead_pend is set when mario_dead = 1 in PLAY.
  - All flags are cleared on any state change.
  - Outside PLAY, level_clear and mario_dead are ignored. Outside TITLE and GAMEOVER, start_pend is held at 0.
- States and outputs (screen_sel / fade / game_run):
  - TITLE (0 / 15 / 0): on a tick with start_pend, go to FADE_IN and load lives = START_LIVES.
  - FADE_IN (1 / ramp / 0): entered with fade = 0 and step_cnt = 0.
    - Each tick: if fade == 15, go to PLAY. Otherwise step_cnt++. When step_cnt reaches FADE_STEP_FRAMES-1, fade++ and step_cnt resets to 0.
    - Duration: 15*FADE_STEP_FRAMES + 1 frames.
  - PLAY (1 / 15 / 1): on a tick, clr_pend goes to WIN, else dead_pend goes to DEATH. If both are set, WIN wins.
  - WIN (2 / 15 / 0): frame_cnt starts at 0 and increments each tick. At the tick where frame_cnt == WIN_FRAMES-1, go to FADE_OUT with fade = 15.
  - DEATH (1 / 15 / 0): holds DEATH_FRAMES frames in the same way. On exit:
    - if lives > 1: lives--, go to FADE_IN;
    - else: lives = 0, go to GAMEOVER.
  - FADE_OUT (2 / ramp / 0): mirror of FADE_IN, fade counting down to 0. At the tick where fade == 0, go to TITLE with fade = 15.
  - GAMEOVER (3 / 15 / 0): on a tick with start_pend, go to TITLE.
- Widths:
  - frame_cnt is 9 bits; step_cnt is 4 bits.
  - Counters reset to 0 on every state entry.
  - fade never wraps; it saturates at 0 and 15 by construction.
- Reset (reset_n = 0 at an edge), including mid-fade or mid-hold:
  - state = TITLE, screen_sel = 0, fade = 15, game_run = 0, lives = 0.
  - All counters, pending flags and the start_btn edge register are cleared.
  - Reset takes effect on that edge regardless of frame_tick.

## Timing
- Outputs are registered. A change decided at the tick edge is visible one cycle later, from pixel (1,0) onward. All outputs are therefore stable for every drawn pixel of the frame.
- Input-to-effect latency:
  - A pulse arriving during frame N takes effect at the tick starting frame N+1.
  - A pulse on the tick edge itself is latched and acts at the following tick.
- A start_btn held high counts as one press. The key must return low before another press registers.
- If DrawX/DrawY never reach (0,0), for example during reset of the VGA controller, the FSM holds its state.

## Test plan
- Reset -> screen_sel = 0, fade = 15, game_run = 0, lives = 0. Apply reset mid-FADE_IN at fade = 7 -> the same values on the next edge.
- start_btn pulse in TITLE (FADE_STEP_FRAMES = 4) -> next tick: screen_sel = 1, fade = 0, lives = 3. fade steps +1 every 4 ticks. game_run = 1 exactly 61 ticks after entry.
- level_clear in PLAY -> screen_sel = 2 for 300 ticks, then fade 15->0 over 61 ticks, then TITLE with fade = 15.
- Three mario_dead pulses, each in PLAY -> lives goes 3->2->1 after 120-frame holds. The third death gives screen_sel = 3, lives = 0. A start press then gives TITLE.
- level_clear and mario_dead in the same cycle -> WIN. lives is unchanged.
- Held start_btn through TITLE->PLAY, plus a start_btn pulse during PLAY -> no extra transition. A level_clear pulse during WIN -> ignored, and the hold length is still exactly 300 frames.
